clock_run_controller: RTL and testbench
=======================================

# clock_run_controller

Run/step sequencer that gates the processor datapath through a single clock-enable, so a free-running `CLOCK` can be started, paused, single-stepped and stopped on halt without touching the clock generator itself. Sits between the testbench/debug front end and the CPU top level; the CPU qualifies every state-changing register with `EN`. Also counts enabled cycles and enforces an optional cycle budget (timeout).

## Interface
Parameters:
- `CYCLE_W`, 32, width of the enabled-cycle counter
- `STEP_W`, 8, width of the step-burst length
- `MAX_CYCLES`, 0, cycle budget; 0 = unlimited

Ports:
- `CLOCK` input 1: single clock, all logic on rising edge
- `RESET` input 1: synchronous, active-high; overrides everything
- `CLEAR` input 1: synchronous soft clear (return to IDLE, clear counter and flags)
- `START` input 1: request continuous run
- `STOP` input 1: request pause
- `STEP` input 1: request burst of `STEP_N` enabled cycles
- `STEP_N` input STEP_W: burst length, sampled with `STEP`; 0 treated as 1
- `HALT` input 1: datapath reports halt instruction retired; only meaningful when `EN`=1
- `EN` output 1: datapath clock enable
- `BUSY` output 1: high in RUN or STEP
- `HALTED` output 1: sticky, halt observed
- `TIMEOUT` output 1: sticky, budget exhausted
- `CYCLES` output CYCLE_W: count of enabled edges, saturating

## Operation
- States: IDLE, RUN, STEP, PAUSE, DONE. Moore outputs: `EN`=`BUSY`=1 in RUN and STEP, else 0.
- Reset values: state IDLE, `EN`=0, `BUSY`=0, `HALTED`=0, `TIMEOUT`=0, `CYCLES`=0, step remainder 0.
- Per-edge priority: `RESET` > `CLEAR` > `HALT`(only if EN) > timeout > `STOP` > `START` > `STEP`.
- IDLE / PAUSE: `START` -> RUN; `STEP` -> STEP, remainder := max(`STEP_N`,1); `STOP` ignored.
- RUN: `HALT` -> DONE, set `HALTED`; timeout -> DONE, set `TIMEOUT`; `STOP` -> PAUSE; `START`/`STEP` ignored.
- STEP: each edge decrements remainder; edge with remainder==1 -> PAUSE; `HALT`/timeout -> DONE as in RUN; `STOP` -> PAUSE immediately (that edge still counts); `START` -> RUN (abandons remainder); `STEP` ignored.
- DONE: `EN`=0; only `RESET` or `CLEAR` leaves (-> IDLE). `HALTED`/`TIMEOUT` held.
- `CYCLES`: +1 on every edge with `EN`=1; saturates at all-ones; cleared by `RESET`/`CLEAR` only (not by PAUSE or START).
- Timeout: with `MAX_CYCLES`≠0, the enabled edge on which `CYCLES` becomes `MAX_CYCLES` moves to DONE. If `HALT` arrives on the same edge, both flags set, state DONE.
- `CLEAR` in RUN aborts mid-run: `EN` low next cycle, counter 0.

## Timing
- Request sampled at edge k -> `EN` high for cycle k+1 (one-cycle latency, registered state).
- `STEP` with `STEP_N`=N from IDLE: `EN` high for exactly N consecutive cycles, `CYCLES` += N.
- `HALT` sampled at edge with `EN`=1: that edge is counted and is the last enabled edge; `EN` low from next cycle.
- `STOP` same: current enabled edge completes, `EN` low next cycle.
- Inputs are level-sampled each edge; held requests re-trigger only from IDLE/PAUSE (held `START` in PAUSE restarts immediately).

## Structure
- Package `clock_run_ctrl_pkg`: state enum `run_state_t` (IDLE, RUN, STEP, PAUSE, DONE) and state encoding constants.
- Single module; no sub-module required. Counter and step remainder live in the same always block set (state register, next-state logic, counters).

## Test plan
- Reset then `START` for 1 cycle, `MAX_CYCLES`=0 -> `EN` rises 1 cycle later; `STOP` after 10 enabled edges -> PAUSE, `CYCLES`=10.
- From IDLE `STEP` with `STEP_N`=3 -> exactly 3 `EN` cycles, state PAUSE, `CYCLES`=3; `STEP_N`=0 -> 1 cycle.
- RUN, `HALT` on 5th enabled edge -> `CYCLES`=5, `HALTED`=1, DONE; subsequent `START` ignored; `CLEAR` -> IDLE, flags and counter 0.
- `MAX_CYCLES`=8, `START` held -> `EN` for 8 cycles, `TIMEOUT`=1, `CYCLES`=8; with `HALT` on edge 8 -> both flags set.
- STEP burst of 5 with `STOP` on 2nd edge -> `CYCLES`=2, PAUSE; `START` during burst -> RUN continues indefinitely.
- `RESET` asserted mid-RUN and simultaneously with `START`/`HALT` -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/clock_run_ctrl_pkg.sv
// Shared types for the run/step clock-enable sequencer.
// Holds the state encoding and the enum used by clock_run_controller.
package clock_run_ctrl_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ENC_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ENC_RUN   = 3'd1;
    localparam logic [ST_W-1:0] ENC_STEP  = 3'd2;
    localparam logic [ST_W-1:0] ENC_PAUSE = 3'd3;
    localparam logic [ST_W-1:0] ENC_DONE  = 3'd4;

    // S_ prefix keeps the enumerators from colliding with the START/STEP/STOP ports.
    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ENC_IDLE,
        S_RUN   = ENC_RUN,
        S_STEP  = ENC_STEP,
        S_PAUSE = ENC_PAUSE,
        S_DONE  = ENC_DONE
    } run_state_t;

endpackage

// File: rtl/clock_run_controller.sv
// Run/step sequencer producing a single datapath clock-enable.
// Ports:
//   CLOCK            rising-edge clock
//   RESET            synchronous active-high reset, overrides everything
//   CLEAR            synchronous soft clear back to IDLE, counter and flags zeroed
//   START/STOP/STEP  run, pause and burst requests (level sampled)
//   STEP_N           burst length sampled with STEP, 0 means 1
//   HALT             datapath halt, honoured only while EN is high
//   EN, BUSY         high in RUN and STEP
//   HALTED, TIMEOUT  sticky status flags
//   CYCLES           saturating count of enabled edges
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | after reset/clear, waiting for START or STEP
// S_RUN   | continuous run, EN high
// S_STEP  | burst of remain enabled cycles, EN high
// S_PAUSE | stopped, resumable with START or STEP
// S_DONE  | halt or budget reached, left only by RESET/CLEAR
module clock_run_controller
    import clock_run_ctrl_pkg::*;
#(
    parameter int unsigned CYCLE_W    = 32,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               CLEAR,
    input  logic               START,
    input  logic               STOP,
    input  logic               STEP,
    input  logic [STEP_W-1:0]  STEP_N,
    input  logic               HALT,
    output logic               EN,
    output logic               BUSY,
    output logic               HALTED,
    output logic               TIMEOUT,
    output logic [CYCLE_W-1:0] CYCLES
);

    localparam logic [CYCLE_W-1:0] BUDGET = CYCLE_W'(MAX_CYCLES);

    run_state_t        state;
    run_state_t        state_next;
    logic [STEP_W-1:0] remain;
    logic [CYCLE_W-1:0] cycles_inc;
    logic              halt_hit;
    logic              timeout_hit;
    logic              load_step;

    // Value CYCLES takes on this edge if enabled; timeout compares against it
    // so the edge that reaches the budget is itself the last enabled edge.
    assign cycles_inc  = (CYCLES == '1) ? CYCLES : CYCLES + CYCLE_W'(1);
    assign halt_hit    = EN && HALT;
    assign timeout_hit = EN && (MAX_CYCLES != 0) && (cycles_inc == BUDGET);

    always_ff @(posedge CLOCK) begin
        if (RESET || CLEAR) begin
            state   <= S_IDLE;
            CYCLES  <= '0;
            remain  <= '0;
            HALTED  <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state <= state_next;
            if (EN)
                CYCLES <= cycles_inc;
            if (halt_hit)
                HALTED <= 1'b1;
            if (timeout_hit)
                TIMEOUT <= 1'b1;
            if (load_step)
                remain <= (STEP_N == '0) ? STEP_W'(1) : STEP_N;
            else if (state == S_STEP)
                remain <= remain - STEP_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        load_step  = 1'b0;
        unique case (state)
            S_IDLE, S_PAUSE: begin
                if (START) begin
                    state_next = S_RUN;
                end else if (STEP) begin
                    state_next = S_STEP;
                    load_step  = 1'b1;
                end
            end
            S_RUN: begin
                if (halt_hit || timeout_hit)
                    state_next = S_DONE;
                else if (STOP)
                    state_next = S_PAUSE;
            end
            S_STEP: begin
                if (halt_hit || timeout_hit)
                    state_next = S_DONE;
                else if (STOP)
                    state_next = S_PAUSE;
                else if (START)
                    state_next = S_RUN;
                else if (remain == STEP_W'(1))
                    state_next = S_PAUSE;
            end
            S_DONE: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        EN   = (state == S_RUN) || (state == S_STEP);
        BUSY = EN;
    end

endmodule

// File: tb/tb_clock_run_controller.sv
module tb_clock_run_controller;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        CLEAR = 1'b0;
    logic        START = 1'b0;
    logic        STOP  = 1'b0;
    logic        STEP  = 1'b0;
    logic [7:0]  STEP_N = 8'd0;
    logic        HALT  = 1'b0;

    logic        en_a, busy_a, halted_a, timeout_a;
    logic [31:0] cycles_a;
    logic        en_b, busy_b, halted_b, timeout_b;
    logic [31:0] cycles_b;

    int total = 0;
    int bad   = 0;
    int cnt;

    always #5 CLOCK = ~CLOCK;

    clock_run_controller #(.CYCLE_W(32), .STEP_W(8), .MAX_CYCLES(0)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .CLEAR(CLEAR), .START(START), .STOP(STOP),
        .STEP(STEP), .STEP_N(STEP_N), .HALT(HALT),
        .EN(en_a), .BUSY(busy_a), .HALTED(halted_a), .TIMEOUT(timeout_a), .CYCLES(cycles_a)
    );

    clock_run_controller #(.CYCLE_W(32), .STEP_W(8), .MAX_CYCLES(8)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .CLEAR(CLEAR), .START(START), .STOP(STOP),
        .STEP(STEP), .STEP_N(STEP_N), .HALT(HALT),
        .EN(en_b), .BUSY(busy_b), .HALTED(halted_b), .TIMEOUT(timeout_b), .CYCLES(cycles_b)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        RESET = 1'b1; tick(1); RESET = 1'b0;
        chk("rst_en", en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_halted", halted_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_cycles", cycles_a, 0);

        // STOP in IDLE is ignored
        STOP = 1'b1; tick(1); STOP = 1'b0;
        chk("idle_stop_en", en_a, 0);

        // START pulse: EN one cycle later, STOP on 10th enabled edge
        START = 1'b1; tick(1); START = 1'b0;
        chk("run_en", en_a, 1);
        chk("run_busy", busy_a, 1);
        chk("run_cycles0", cycles_a, 0);
        tick(9);
        chk("run_cycles9", cycles_a, 9);
        STOP = 1'b1; tick(1); STOP = 1'b0;
        chk("stop_en", en_a, 0);
        chk("stop_cycles", cycles_a, 10);
        tick(3);
        chk("pause_hold_cycles", cycles_a, 10);
        chk("pause_hold_en", en_a, 0);
        // START from PAUSE resumes without clearing the counter
        START = 1'b1; tick(1); START = 1'b0;
        chk("resume_en", en_a, 1);
        chk("resume_cycles", cycles_a, 10);
        tick(2);
        chk("resume_cycles2", cycles_a, 12);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        chk("clear_run_en", en_a, 0);
        chk("clear_run_cycles", cycles_a, 0);

        // STEP burst of 3
        STEP_N = 8'd3; STEP = 1'b1; tick(1); STEP = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (en_a) cnt++;
            tick(1);
        end
        chk("step3_en_cycles", cnt, 3);
        chk("step3_cycles", cycles_a, 3);
        chk("step3_en_after", en_a, 0);
        // STEP_N = 0 behaves as 1
        STEP_N = 8'd0; STEP = 1'b1; tick(1); STEP = 1'b0;
        chk("step0_en", en_a, 1);
        tick(1);
        chk("step0_en_after", en_a, 0);
        chk("step0_cycles", cycles_a, 4);
        // still resumable, so PAUSE rather than DONE
        START = 1'b1; tick(1); START = 1'b0;
        chk("step_pause_resume_en", en_a, 1);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;

        // HALT on 5th enabled edge
        START = 1'b1; tick(1); START = 1'b0;
        tick(4);
        chk("halt_pre_cycles", cycles_a, 4);
        HALT = 1'b1; tick(1); HALT = 1'b0;
        chk("halt_cycles", cycles_a, 5);
        chk("halt_flag", halted_a, 1);
        chk("halt_en", en_a, 0);
        chk("halt_timeout", timeout_a, 0);
        START = 1'b1; tick(2); START = 1'b0;
        chk("done_start_ignored", en_a, 0);
        chk("done_cycles_held", cycles_a, 5);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        chk("clr_halted", halted_a, 0);
        chk("clr_cycles", cycles_a, 0);
        chk("clr_en", en_a, 0);

        // Budget of 8 on dut_b with START held
        RESET = 1'b1; tick(1); RESET = 1'b0;
        START = 1'b1; tick(1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (en_b) cnt++;
            tick(1);
        end
        START = 1'b0;
        chk("to_en_cycles", cnt, 8);
        chk("to_flag", timeout_b, 1);
        chk("to_cycles", cycles_b, 8);
        chk("to_halted", halted_b, 0);
        chk("to_en", en_b, 0);
        chk("nobudget_en", en_a, 1);
        chk("nobudget_timeout", timeout_a, 0);

        // HALT on the budget edge sets both flags
        RESET = 1'b1; tick(1); RESET = 1'b0;
        START = 1'b1; tick(1); START = 1'b0;
        tick(7);
        chk("to_halt_pre", cycles_b, 7);
        HALT = 1'b1; tick(1); HALT = 1'b0;
        chk("to_halt_cycles", cycles_b, 8);
        chk("to_halt_timeout", timeout_b, 1);
        chk("to_halt_halted", halted_b, 1);
        chk("to_halt_en", en_b, 0);

        // STEP burst of 5 with STOP on 2nd edge
        RESET = 1'b1; tick(1); RESET = 1'b0;
        STEP_N = 8'd5; STEP = 1'b1; tick(1); STEP = 1'b0;
        tick(1);
        STOP = 1'b1; tick(1); STOP = 1'b0;
        chk("step_stop_cycles", cycles_a, 2);
        chk("step_stop_en", en_a, 0);
        tick(2);
        chk("step_stop_held", cycles_a, 2);
        // START during burst abandons the remainder and keeps running
        STEP = 1'b1; tick(1); STEP = 1'b0;
        tick(1);
        START = 1'b1; tick(1); START = 1'b0;
        chk("step_start_cycles", cycles_a, 4);
        tick(10);
        chk("step_start_en", en_a, 1);
        chk("step_start_cycles2", cycles_a, 14);

        // RESET mid-run, then together with START and HALT
        RESET = 1'b1; tick(1); RESET = 1'b0;
        chk("rst_mid_en", en_a, 0);
        chk("rst_mid_cycles", cycles_a, 0);
        START = 1'b1; tick(1); START = 1'b0;
        tick(3);
        RESET = 1'b1; START = 1'b1; HALT = 1'b1; tick(1);
        RESET = 1'b0; START = 1'b0; HALT = 1'b0;
        chk("rst_combo_en", en_a, 0);
        chk("rst_combo_busy", busy_a, 0);
        chk("rst_combo_halted", halted_a, 0);
        chk("rst_combo_timeout", timeout_a, 0);
        chk("rst_combo_cycles", cycles_a, 0);
        chk("rst_combo_en_b", en_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
